// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared definitions for the pipeline hazard / stall controller:
//   - default busy lengths of the multi-cycle mult/div unit
//   - Tuse / Tnew encodings (2-bit constants T0..T2)
//   - busy-counter state encoding
//   - src_hazard(): RAW check of one D-stage source against E and M
// ---------------------------------------------------------------------------
package hazard_ctrl_pkg;

   localparam int MULT_CYC_DEF = 5;    // busy cycles after mult/multu
   localparam int DIV_CYC_DEF  = 10;   // busy cycles after div/divu

   // Tuse: cycles until the D instruction needs the operand.
   // Tnew: cycles until the E/M instruction produces its result.
   localparam logic [1:0] T0 = 2'd0;
   localparam logic [1:0] T1 = 2'd1;
   localparam logic [1:0] T2 = 2'd2;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   // A source stalls when it matches a pending destination whose value
   // will not be ready by the time the D instruction consumes it.
   // Register 0 is hard-wired zero and never creates a dependency.
   function automatic logic src_hazard(
      input logic       use_src,
      input logic [4:0] src,
      input logic [1:0] tuse,
      input logic [4:0] a3_e,
      input logic [1:0] tnew_e,
      input logic [4:0] a3_m,
      input logic [1:0] tnew_m
   );
      logic hit_e;
      logic hit_m;
      hit_e = (src == a3_e) && (tnew_e > tuse);
      hit_m = (src == a3_m) && (tnew_m > tuse);
      return use_src && (src != 5'd0) && (hit_e || hit_m);
   endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// ---------------------------------------------------------------------------
// md_busy_cnt
// Busy counter of the multi-cycle mult/div unit. An issue loads DIV_CYC or
// MULT_CYC; the count drops by one per clock and busy stays high while it
// is non-zero. A frozen pipe (hold) freezes the counter as well, including
// a pending issue. An issue while already busy simply reloads.
//
// Ports:
//   clk    in   core clock
//   reset  in   asynchronous, active-low
//   start  in   mult/div instruction in E this cycle
//   isDiv  in   qualifies start: 1 = div/divu, 0 = mult/multu
//   hold   in   pipeline frozen, counter holds
//   busy   out  unit busy (registered)
// ---------------------------------------------------------------------------
module md_busy_cnt
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic isDiv,
   input  logic hold,
   output logic busy
);

   localparam int MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   md_state_e        state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             busy_reg;
   logic [CNT_W-1:0] load_next;

   assign load_next = isDiv ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);

   // busy_reg mirrors (cnt_reg != 0) but is registered directly so the
   // output is a flop, not a compare.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= MD_IDLE;
         cnt_reg   <= '0;
         busy_reg  <= 1'b0;
      end else if (!hold) begin
         if (start) begin
            state_reg <= MD_BUSY;
            cnt_reg   <= load_next;
            busy_reg  <= 1'b1;
         end else if (state_reg == MD_BUSY) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
               state_reg <= MD_IDLE;
               busy_reg  <= 1'b0;
            end
         end
      end
   end

   assign busy = busy_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Hazard and stall controller of the five-stage MIPS pipeline. Checks the
// D-stage sources against the E/M destinations using Tuse/Tnew, tracks the
// mult/div unit, and drives enables/flushes of the PC, IF/ID, ID/EX and
// EX/MEM registers.
//
// Priority: extStall (freeze everything, no bubble) > stall (hold PC and
// IF/ID, inject a bubble into E) > normal flow.
//
// Build option: define HAZ_PERF_CNT_EN to add the stallCnt port, a 32-bit
// wrapping count of clock edges on which a hazard stall took effect.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   rsD, rtD              D-stage source registers
//   useRsD, useRtD        D instruction reads rs / rt
//   tuseRsD, tuseRtD      Tuse of rs / rt
//   A3E, A3M              destination registers in E / M (0 = none)
//   tnewE, tnewM          Tnew of E / M instruction
//   mdUseD                D instruction uses the mult/div unit
//   mdStartE, mdDivE      mult/div issue in E, 1 = div
//   extStall              external freeze request
//   pcEn, fdEn, deEn, emEn   pipeline register enables
//   deFlush, emFlush      pipeline register flushes
//   mdBusy                mult/div unit busy
//   stallCnt              stall cycle count (HAZ_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rsD,
   input  logic [4:0]  rtD,
   input  logic        useRsD,
   input  logic        useRtD,
   input  logic [1:0]  tuseRsD,
   input  logic [1:0]  tuseRtD,
   input  logic [4:0]  A3E,
   input  logic [4:0]  A3M,
   input  logic [1:0]  tnewE,
   input  logic [1:0]  tnewM,
   input  logic        mdUseD,
   input  logic        mdStartE,
   input  logic        mdDivE,
   input  logic        extStall,
   output logic        pcEn,
   output logic        fdEn,
   output logic        deEn,
   output logic        emEn,
   output logic        deFlush,
   output logic        emFlush,
   output logic        mdBusy
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [31:0] stallCnt
`endif
);

   // Index 0 = rs, index 1 = rt; both sources share one comparator shape.
   logic [4:0] src_reg_num [2];
   logic       src_use     [2];
   logic [1:0] src_tuse    [2];
   logic [1:0] src_stall;
   logic       stall_md;
   logic       stall;

   assign src_reg_num[0] = rsD;
   assign src_reg_num[1] = rtD;
   assign src_use[0]     = useRsD;
   assign src_use[1]     = useRtD;
   assign src_tuse[0]    = tuseRsD;
   assign src_tuse[1]    = tuseRtD;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         assign src_stall[gi] = src_hazard(src_use[gi], src_reg_num[gi],
                                           src_tuse[gi], A3E, tnewE,
                                           A3M, tnewM);
      end
   endgenerate

   // The mult/div issue in E is counted as busy already, so a back-to-back
   // mfhi/mflo waits without the counter needing a lookahead.
   assign stall_md = mdUseD & (mdBusy | mdStartE);
   assign stall    = (|src_stall) | stall_md;

   md_busy_cnt #(
      .MULT_CYC (MULT_CYC),
      .DIV_CYC  (DIV_CYC)
   ) u_md_busy_cnt (
      .clk   (clk),
      .reset (reset),
      .start (mdStartE),
      .isDiv (mdDivE),
      .hold  (extStall),
      .busy  (mdBusy)
   );

   always_comb begin
      pcEn    = 1'b1;
      fdEn    = 1'b1;
      deEn    = 1'b1;
      emEn    = 1'b1;
      deFlush = 1'b0;
      if (extStall) begin
         pcEn = 1'b0;
         fdEn = 1'b0;
         deEn = 1'b0;
         emEn = 1'b0;
      end else if (stall) begin
         pcEn    = 1'b0;
         fdEn    = 1'b0;
         deFlush = 1'b1;
      end
   end

   // Reserved for the exception path; this block never flushes EX/MEM.
   assign emFlush = 1'b0;

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cnt_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_reg <= '0;
      end else if (stall && !extStall) begin
         stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
   end

   assign stallCnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Table of combinational hazard vectors followed by hand-written sequences
// for the mult/div busy window, freeze hold, stall counter and reset.
// Outputs are packed as {pcEn, fdEn, deEn, emEn, deFlush, emFlush}.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam logic [5:0] O_NORM   = 6'b111100;
   localparam logic [5:0] O_STALL  = 6'b001110;
   localparam logic [5:0] O_FREEZE = 6'b000000;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rsD, rtD, A3E, A3M;
   logic        useRsD, useRtD, mdUseD, mdStartE, mdDivE, extStall;
   logic [1:0]  tuseRsD, tuseRtD, tnewE, tnewM;
   logic        pcEn, fdEn, deEn, emEn, deFlush, emFlush, mdBusy;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stallCnt;
`endif
   logic [5:0]  outs;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign outs = {pcEn, fdEn, deEn, emEn, deFlush, emFlush};

   hazard_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .rsD      (rsD),
      .rtD      (rtD),
      .useRsD   (useRsD),
      .useRtD   (useRtD),
      .tuseRsD  (tuseRsD),
      .tuseRtD  (tuseRtD),
      .A3E      (A3E),
      .A3M      (A3M),
      .tnewE    (tnewE),
      .tnewM    (tnewM),
      .mdUseD   (mdUseD),
      .mdStartE (mdStartE),
      .mdDivE   (mdDivE),
      .extStall (extStall),
      .pcEn     (pcEn),
      .fdEn     (fdEn),
      .deEn     (deEn),
      .emEn     (emEn),
      .deFlush  (deFlush),
      .emFlush  (emFlush),
      .mdBusy   (mdBusy)
`ifdef HAZ_PERF_CNT_EN
      ,
      .stallCnt (stallCnt)
`endif
   );

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       use_rs;
      logic       use_rt;
      logic [1:0] tuse_rs;
      logic [1:0] tuse_rt;
      logic [4:0] a3e;
      logic [4:0] a3m;
      logic [1:0] tnew_e;
      logic [1:0] tnew_m;
      logic       md_use;
      logic       ext;
      logic [5:0] exp_o;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic clear_inputs();
      rsD = 0; rtD = 0; A3E = 0; A3M = 0;
      useRsD = 0; useRtD = 0; tuseRsD = 0; tuseRtD = 0;
      tnewE = 0; tnewM = 0;
      mdUseD = 0; mdStartE = 0; mdDivE = 0; extStall = 0;
   endtask

   task automatic apply(input vec_t v);
      rsD = v.rs; rtD = v.rt; useRsD = v.use_rs; useRtD = v.use_rt;
      tuseRsD = v.tuse_rs; tuseRtD = v.tuse_rt;
      A3E = v.a3e; A3M = v.a3m; tnewE = v.tnew_e; tnewM = v.tnew_m;
      mdUseD = v.md_use; extStall = v.ext;
      mdStartE = 0; mdDivE = 0;
   endtask

   // RAW on rs against E (rs=8, Tuse 0, Tnew 2)
   task automatic raw_stall_inputs();
      clear_inputs();
      rsD = 5'd8; useRsD = 1; tuseRsD = 2'd0; A3E = 5'd8; tnewE = 2'd2;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 0;
      #1;
      reset = 1;
   endtask

   initial begin
      //        rs  rt  urs urt trs trt a3e a3m tE tM md ext expected
      vecs[0]  = '{8, 0, 1, 0, 0, 0, 8, 0, 2, 0, 0, 0, O_STALL};   // RAW on E
      vecs[1]  = '{8, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, O_NORM};    // no dest
      vecs[2]  = '{0, 9, 0, 1, 0, 1, 0, 9, 0, 1, 0, 0, O_NORM};    // Tnew=Tuse
      vecs[3]  = '{0, 9, 0, 1, 0, 1, 0, 9, 0, 2, 0, 0, O_STALL};   // Tnew>Tuse M
      vecs[4]  = '{0, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, O_NORM};    // $0
      vecs[5]  = '{8, 0, 1, 0, 1, 0, 8, 0, 1, 0, 0, 0, O_NORM};    // 1>1 false
      vecs[6]  = '{8, 0, 1, 0, 0, 0, 8, 0, 1, 0, 0, 0, O_STALL};   // 1>0
      vecs[7]  = '{8, 0, 0, 0, 0, 0, 8, 0, 2, 0, 0, 0, O_NORM};    // rs unused
      vecs[8]  = '{8, 0, 1, 0, 0, 0, 8, 0, 2, 0, 0, 1, O_FREEZE};  // ext beats stall
      vecs[9]  = '{3, 4, 1, 1, 0, 0, 5, 6, 2, 2, 0, 1, O_FREEZE};  // ext alone
      vecs[10] = '{8, 0, 1, 0, 0, 0, 0, 8, 0, 1, 0, 0, O_STALL};   // RAW on M
      vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_NORM};    // md idle

      clear_inputs();
      reset = 0;
      #2;
      chk("reset_busy", 32'(mdBusy), 32'd0);
      chk("reset_outs", 32'(outs), 32'(O_NORM));
`ifdef HAZ_PERF_CNT_EN
      chk("reset_cnt", stallCnt, 32'd0);
`endif
      @(negedge clk);
      reset = 1;

      // ---- table vectors: each held across exactly one posedge ----
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         apply(vecs[i]);
         #1;
         $display("vec %0d: outs=%b expected=%b", i, outs, vecs[i].exp_o);
         chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(vecs[i].exp_o));
         chk($sformatf("vec%0d_busy", i), 32'(mdBusy), 32'd0);
      end
      @(negedge clk);
      clear_inputs();
`ifdef HAZ_PERF_CNT_EN
      // stall vectors without ext: 0, 3, 6, 10
      chk("table_cnt", stallCnt, 32'd4);
`endif

      // ---- div issue: busy exactly 10 cycles, mdUseD stalls throughout ----
      pulse_reset();
      @(negedge clk);
      mdStartE = 1; mdDivE = 1; mdUseD = 1;
      #1;
      $display("div issue: outs=%b busy=%b", outs, mdBusy);
      chk("div_issue_outs", 32'(outs), 32'(O_STALL));
      chk("div_issue_busy", 32'(mdBusy), 32'd0);
      @(negedge clk);
      mdStartE = 0; mdDivE = 0;
      for (int k = 0; k < 12; k++) begin
         #1;
         $display("div cycle %0d: busy=%b outs=%b", k, mdBusy, outs);
         chk($sformatf("div_busy%0d", k), 32'(mdBusy), (k < 10) ? 32'd1 : 32'd0);
         chk($sformatf("div_outs%0d", k), 32'(outs),
             (k < 10) ? 32'(O_STALL) : 32'(O_NORM));
         @(negedge clk);
      end
`ifdef HAZ_PERF_CNT_EN
      chk("div_cnt", stallCnt, 32'd11);
`endif
      clear_inputs();

      // ---- mult issue, then freeze with RAW pending: counter holds ----
      pulse_reset();
      @(negedge clk);
      mdStartE = 1;
      @(negedge clk);
      mdStartE = 0;                 // count 5
      @(negedge clk);               // count 4
      @(negedge clk);               // count 3
      raw_stall_inputs();
      extStall = 1;
      for (int k = 0; k < 4; k++) begin
         #1;
         $display("freeze cycle %0d: busy=%b outs=%b", k, mdBusy, outs);
         chk($sformatf("frz_outs%0d", k), 32'(outs), 32'(O_FREEZE));
         chk($sformatf("frz_busy%0d", k), 32'(mdBusy), 32'd1);
         @(negedge clk);
      end
      clear_inputs();               // released with count still 3
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         $display("post-freeze cycle %0d: busy=%b", k, mdBusy);
         chk($sformatf("post_frz_busy%0d", k), 32'(mdBusy), (k < 2) ? 32'd1 : 32'd0);
      end
`ifdef HAZ_PERF_CNT_EN
      chk("frz_cnt", stallCnt, 32'd0);
`endif

      // ---- 7 RAW stall cycles, 3 of them frozen ----
      pulse_reset();
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         raw_stall_inputs();
         extStall = (k % 2 == 1);
         #1;
         $display("perf cycle %0d: ext=%b outs=%b", k, extStall, outs);
         chk($sformatf("perf_outs%0d", k), 32'(outs),
             extStall ? 32'(O_FREEZE) : 32'(O_STALL));
      end
      @(negedge clk);
      clear_inputs();
`ifdef HAZ_PERF_CNT_EN
      chk("perf_cnt", stallCnt, 32'd4);
`endif

      // ---- reset while the div counter sits at 6 ----
      @(negedge clk);
      mdStartE = 1; mdDivE = 1;
      @(negedge clk);
      mdStartE = 0; mdDivE = 0;     // count 10
      repeat (4) @(negedge clk);    // count 6
      #1;
      chk("pre_rst_busy", 32'(mdBusy), 32'd1);
      reset = 0;
      #1;
      $display("mid-busy reset: busy=%b outs=%b", mdBusy, outs);
      chk("mid_rst_busy", 32'(mdBusy), 32'd0);
      chk("mid_rst_outs", 32'(outs), 32'(O_NORM));
`ifdef HAZ_PERF_CNT_EN
      chk("mid_rst_cnt", stallCnt, 32'd0);
`endif
      reset = 1;
      @(negedge clk);
      #1;
      chk("after_rst_busy", 32'(mdBusy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. Compares D-stage source registers against E/M-stage destinations using Tuse/Tnew, tracks the multi-cycle mult/div unit, and drives the enable/flush inputs of the PC, IF/ID, ID/EX and EX/MEM pipeline registers. Sits beside the decoder; all outputs go straight to the pipeline register control pins.

## Interface
- MULT_CYC, 5, busy cycles after a mult/multu issue
- DIV_CYC, 10, busy cycles after a div/divu issue
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low (0 = reset)
- rsD, rtD  in  5 each  D-stage source register numbers
- useRsD, useRtD  in  1 each  D instruction reads rs / rt
- tuseRsD, tuseRtD  in  2 each  Tuse for rs / rt (0 or 1)
- A3E, A3M  in  5 each  destination register in E / M (0 = none)
- tnewE, tnewM  in  2 each  Tnew of the E / M instruction
- mdUseD  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- mdStartE  in  1  E instruction is mult/multu/div/divu
- mdDivE  in  1  qualifies mdStartE: 1 = div, 0 = mult
- extStall  in  1  external freeze request (memory wait)
- pcEn, fdEn, deEn, emEn  out  1 each  enables of PC, IF/ID, ID/EX, EX/MEM
- deFlush, emFlush  out  1 each  flushes of ID/EX, EX/MEM
- mdBusy  out  1  mult/div unit busy
- stallCnt  out  32  stall cycle count (only with HAZ_PERF_CNT_EN)

## Operation
- stallRs = useRsD & rsD!=0 & ((rsD==A3E & tnewE>tuseRsD) | (rsD==A3M & tnewM>tuseRsD)); stallRt identical on rt.
- stallMd = mdUseD & (mdBusy | mdStartE).
- stall = stallRs | stallRt | stallMd.
- Priority: extStall > stall > normal.
  - extStall=1: pcEn=fdEn=deEn=emEn=0, deFlush=emFlush=0 (whole pipe frozen, no bubble).
  - stall=1: pcEn=fdEn=0, deFlush=1, deEn=1, emEn=1, emFlush=0 (bubble into E).
  - normal: all enables 1, all flushes 0.
- emFlush is 0 in every mode; it exists for the exception path and stays tied low in this block.
- Busy counter mdCnt (4 bits, must hold DIV_CYC):
  - states IDLE (mdCnt==0) and BUSY (mdCnt>0); mdBusy = (mdCnt!=0).
  - IDLE -> BUSY: at posedge with mdStartE=1 and extStall=0; load DIV_CYC if mdDivE else MULT_CYC.
  - BUSY: decrement by 1 per posedge while extStall=0; hold while extStall=1.
  - mdStartE while BUSY (cannot occur with correct decode): reload, no error.
  - BUSY -> IDLE when mdCnt reaches 0.

## Timing
- Stall/enable/flush outputs combinational from inputs and mdCnt; no added latency.
- mdBusy registered: high from the cycle after issue for exactly MULT_CYC / DIV_CYC cycles (absent extStall).
- Reset (async, reset=0): mdCnt=0, mdBusy=0, stallCnt=0; combinational outputs follow inputs immediately. Reset mid-BUSY clears instantly.
- Register 0 never causes a stall regardless of A3E/A3M.

## Configuration
- HAZ_PERF_CNT_EN defined: stallCnt increments by 1 each posedge where stall=1 and extStall=0; wraps 0xFFFFFFFF -> 0.
- Undefined: stallCnt port absent, no counter logic.

## Structure
- Shared package/header: MULT_CYC/DIV_CYC defaults, Tuse/Tnew encodings (2-bit constants T0..T2).
- One sub-module, md_busy_cnt: the mult/div busy counter (inputs clk, reset, start, isDiv, hold; output busy).
- Hazard comparators and priority mux stay in the top module.

## Test plan
- rsD=8, useRsD=1, tuseRsD=0, A3E=8, tnewE=2 -> pcEn=0, fdEn=0, deFlush=1; with A3E=0 -> no stall.
- rtD=9, tuseRtD=1, A3M=9, tnewM=1 -> no stall; tnewM=2 -> stall.
- mdStartE=1, mdDivE=1 for one cycle -> mdBusy high exactly 10 cycles; mdUseD=1 during that window -> stall every cycle, released the cycle mdBusy falls.
- extStall=1 concurrent with a RAW stall -> all enables 0, deFlush=0; mdCnt holds value.
- reset=0 while mdCnt=6 -> mdBusy=0 immediately, stallCnt=0.
- HAZ_PERF_CNT_EN: 7 stall cycles, 3 with extStall=1 -> stallCnt=4.
